// File: rtl/ex_pkg.sv
// Shared constants for the execute-to-memory stage: branch condition codes,
// result-source encodings, skid-buffer state encoding and entry sizing.
package ex_pkg;

  // Branch condition codes (funct3)
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // Write-back result source select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } state_e;

  // Packed entry: {res, store_data, pc_plus4, rd, reg_write, mem_write, result_src}
  function automatic int unsigned entry_width(input int unsigned xlen, input int unsigned ra_w);
    return 3 * xlen + ra_w + 4;
  endfunction

  localparam int unsigned ENTRY_W = entry_width(32, 5);

endpackage

// File: rtl/branch_cond_unit.sv
// Combinational branch resolution from ALU flags. Signed vs unsigned compare
// is selected upstream, so lt is used as-is for both signednesses.
module branch_cond_unit
  import ex_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_branch,
  input  logic       is_jump,
  input  logic       zero,
  input  logic       lt,
  output logic       taken
);

  logic cond;

  // Decode the condition code against the flags; jumps override everything
  always_comb begin
    cond = 1'b0;
    case (funct3)
      BEQ:         cond = zero;
      BNE:         cond = ~zero;
      BLT, BLTU:   cond = lt;
      BGE, BGEU:   cond = ~lt;
      default:     cond = 1'b0;
    endcase
    taken = is_jump | (is_branch & cond);
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline stage: 2-entry skid buffer (EMPTY/ONE/FULL) with
// valid/ready on both sides, plus a registered one-cycle PC redirect for taken
// branches and jumps. Optional counters enabled by EX_MEM_STATS_EN.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_zero,
  input  logic            alu_lt,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] br_target,
  input  logic [RA_W-1:0] rd,
  input  logic            reg_write,
  input  logic            mem_write,
  input  logic [1:0]      result_src,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_mem_write,
  output logic [1:0]      out_result_src,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef EX_MEM_STATS_EN
  ,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_stall
`endif
);

  localparam int unsigned EntryW = entry_width(XLEN, RA_W);

  state_e            state_q;
  logic [EntryW-1:0] slot0_q, slot1_q;
  logic [EntryW-1:0] in_entry;
  logic              redirect_valid_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic              in_fire, out_fire, taken, redirect_set;

  branch_cond_unit u_branch_cond (
    .funct3    (funct3),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .zero      (alu_zero),
    .lt        (alu_lt),
    .taken     (taken)
  );

  assign in_entry = {alu_res, store_data, pc_plus4, rd, reg_write, mem_write, result_src};

  assign in_ready     = (state_q != StFull);
  assign out_valid    = (state_q != StEmpty);
  assign in_fire      = in_valid & in_ready;
  assign out_fire     = out_valid & out_ready;
  // A flushed bundle is dropped entirely, including its redirect
  assign redirect_set = in_fire & taken & ~flush;

  // slot0_q is always the head; on a FULL pop the tail shifts into it
  assign {out_res, out_store_data, out_pc_plus4, out_rd,
          out_reg_write, out_mem_write, out_result_src} = slot0_q;

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  // Skid-buffer FSM with entry storage and registered redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StEmpty;
      slot0_q          <= '0;
      slot1_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_set;
      if (redirect_set) begin
        redirect_pc_q <= br_target;
      end
      if (flush) begin
        state_q <= StEmpty;
      end else begin
        case (state_q)
          StEmpty: begin
            if (in_fire) begin
              slot0_q <= in_entry;
              state_q <= StOne;
            end
          end
          StOne: begin
            if (in_fire && out_fire) begin
              slot0_q <= in_entry;
            end else if (in_fire) begin
              slot1_q <= in_entry;
              state_q <= StFull;
            end else if (out_fire) begin
              state_q <= StEmpty;
            end
          end
          StFull: begin
            if (out_fire) begin
              slot0_q <= slot1_q;
              state_q <= StOne;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

`ifdef EX_MEM_STATS_EN
  logic [31:0] stat_taken_q, stat_stall_q;

  // Free-running wrap-around counters; flush does not touch them
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (redirect_set) begin
        stat_taken_q <= stat_taken_q + 32'd1;
      end
      if (in_valid && !in_ready) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_taken = stat_taken_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline stage directly downstream of the ALU.
- Captures ALU result, zero and less-than flags, and the execute-stage control/data bundle. Holds them in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Resolves conditional branches and jumps from the ALU flags and issues a registered one-cycle PC redirect toward fetch.

Parameters:
- XLEN, 32, datapath width (ALU result, store data, PCs).
- RA_W, 5, register-file address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  execute bundle valid.
- in_ready  output  1  stage can accept a bundle; registered, equals state!=FULL.
- alu_res  input  XLEN  ALU result.
- alu_zero  input  1  ALU zero flag.
- alu_lt  input  1  ALU less-than. Execute drives ALU Ctrl=LT for blt/bge and Ctrl=LTU for bltu/bgeu, so this flag is used as-is for both.
- store_data  input  XLEN  rs2 value for stores.
- pc_plus4  input  XLEN  PC+4 of the instruction.
- br_target  input  XLEN  precomputed PC+imm or jalr target.
- rd  input  RA_W  destination register.
- reg_write  input  1  writes register file.
- mem_write  input  1  store.
- result_src  input  2  00 ALU, 01 memory, 10 PC+4.
- is_branch  input  1  conditional branch.
- is_jump  input  1  jal/jalr.
- funct3  input  3  branch condition code.
- flush  input  1  synchronous kill of buffered entries.
- out_valid  output  1  head entry valid.
- out_ready  input  1  memory stage accepts head.
- out_res, out_store_data, out_pc_plus4  output  XLEN  head fields.
- out_rd  output  RA_W  head field.
- out_reg_write, out_mem_write  output  1  head fields.
- out_result_src  output  2  head field.
- redirect_valid  output  1  one-cycle taken-branch/jump pulse.
- redirect_pc  output  XLEN  target, valid with redirect_valid.

Behaviour:
- Transfer rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States and transitions (EMPTY, ONE, FULL):
  - EMPTY→ONE on in_fire.
  - ONE→FULL on in_fire & !out_fire.
  - ONE→EMPTY on out_fire & !in_fire.
  - ONE→ONE on in_fire & out_fire.
  - FULL→ONE on out_fire. No push is possible while FULL.
- Ordering: FIFO. Output fields always come from the head entry. Zero-cycle pass-through is not allowed: an entry appears on out_* the cycle after in_fire.
- Branch condition: taken is evaluated on in_fire.
  - 000 beq: zero.
  - 001 bne: !zero.
  - 100 blt and 110 bltu: lt.
  - 101 bge and 111 bgeu: !lt.
  - 010 and 011: not taken.
  - is_jump forces taken regardless of funct3.
- Redirect: when taken, redirect_valid=1 and redirect_pc=br_target on the next cycle only. redirect_valid is otherwise 0 and redirect_pc holds its last value.
- Buffering of branches/jumps: every accepted bundle is buffered, branches included. Branches arrive with reg_write=0 and mem_write=0; jumps with result_src=10.
- Flush:
  - State→EMPTY and out_valid=0 next cycle.
  - Any same-cycle in_fire is dropped and produces no redirect.
  - flush does not cancel a redirect pulse already registered.
- Reset: applies on the edge with rst=1 and overrides flush. Values after reset:
  - state EMPTY, in_ready=1, out_valid=0, redirect_valid=0, redirect_pc=0.
  - All buffered fields 0.
  - Reset mid-transfer discards all entries.
- Output stability: with out_valid=1 and out_ready=0, all out_* fields hold stable.

Optional Feature:
- Macro: EX_MEM_STATS_EN.
- Defined:
  - Adds output stat_taken (32) counting redirect pulses and output stat_stall (32) counting cycles with in_valid & !in_ready.
  - Both counters wrap at 2^32, clear on rst, and are not affected by flush.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package ex_pkg holds:
  - funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - RES_ALU/RES_MEM/RES_PC4 encodings.
  - State encoding EMPTY/ONE/FULL.
  - Packed entry width constant.
- Sub-module: branch_cond_unit, combinational {funct3, is_branch, is_jump, zero, lt} → taken.
- The skid buffer stays inline.

Test Plan:
- Reset, then one bundle (alu_res=0x0000_0010, rd=5, reg_write=1) with out_ready=1 → out_valid next cycle, out_res=0x10, out_rd=5; state returns to EMPTY.
- Push 3 bundles back-to-back with out_ready=0 → first two accepted, in_ready=0 after the second, third held. Raise out_ready → order preserved: 1, 2, then 3.
- Each branch case:
  - beq with zero=1, br_target=0x100 → redirect_valid pulses one cycle with redirect_pc=0x100.
  - bne with zero=1 → no pulse.
  - bltu with lt=1 → pulse.
  - bge with lt=1 → no pulse.
  - funct3=010 → no pulse.
- jal with pc_plus4=0x24, br_target=0x80 → redirect to 0x80; buffered entry has result_src=10 and out_pc_plus4=0x24.
- FULL state, then flush together with in_valid of a taken beq → out_valid=0 next cycle, in_ready=1, no redirect.
- rst asserted with flush and 2 entries buffered → all outputs at reset values. With EX_MEM_STATS_EN, the counters read 0.
